// File: rtl/ppfifo_write_arbiter_if.sv
// Bus bundle between the two requesters, the ppfifo write port and the write arbiter.
// slave = arbiter side, master = requester/ppfifo side.
interface ppfifo_write_arbiter_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  req0_request;
   logic                  req0_strobe;
   logic [DATA_WIDTH-1:0] req0_data;
   logic                  req0_grant;
   logic                  req0_space;

   logic                  req1_request;
   logic                  req1_strobe;
   logic [DATA_WIDTH-1:0] req1_data;
   logic                  req1_grant;
   logic                  req1_space;

   logic [1:0]            ppfifo_write_ready;
   logic [23:0]           ppfifo_write_fifo_size;
   logic [1:0]            ppfifo_write_activate;
   logic                  ppfifo_write_strobe;
   logic [DATA_WIDTH-1:0] ppfifo_write_data;
   logic                  busy;

   modport slave (
      input  req0_request, req0_strobe, req0_data,
      input  req1_request, req1_strobe, req1_data,
      input  ppfifo_write_ready, ppfifo_write_fifo_size,
      output req0_grant, req0_space, req1_grant, req1_space,
      output ppfifo_write_activate, ppfifo_write_strobe, ppfifo_write_data, busy
   );

   modport master (
      output req0_request, req0_strobe, req0_data,
      output req1_request, req1_strobe, req1_data,
      output ppfifo_write_ready, ppfifo_write_fifo_size,
      input  req0_grant, req0_space, req1_grant, req1_space,
      input  ppfifo_write_activate, ppfifo_write_strobe, ppfifo_write_data, busy
   );
endinterface

// File: rtl/ppfifo_write_arbiter.sv
// Round-robin arbiter sharing one ppfifo write port between two requesters (write_clock domain).
// Define PPFIFO_WRITE_ARB_TIMEOUT_EN to force-close partial buffers after TIMEOUT_CYCLES idle cycles.
//
// state    | meaning
// S_IDLE   | no buffer open; arbitrate when a request and a ready buffer exist
// S_ACTIVE | buffer open and granted; accepting words from the granted requester
// S_FLUSH  | grant dropped; activate held one cycle so the last strobe lands
module ppfifo_write_arbiter #(
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                   write_clock,
   input  logic                   reset,
   ppfifo_write_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FLUSH} state_t;

   state_t                r_state, w_state_next;
   logic [1:0]            r_activate, w_activate_next;
   logic [1:0]            r_grant, w_grant_next;
   logic                  r_last_grant, w_last_grant_next;
   logic [23:0]           r_count, w_count_next;
   logic                  r_strobe, w_strobe_next;
   logic [DATA_WIDTH-1:0] r_data, w_data_next;

   logic                  w_sel;
   logic                  w_req;
   logic                  w_stb;
   logic [DATA_WIDTH-1:0] w_din;
   logic                  w_has_space;
   logic                  w_accept;
   logic [23:0]           w_count_inc;
   logic                  w_full;
   logic                  w_any_req;
   logic                  w_both_req;
   logic                  w_win;
   logic                  w_timeout;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   assign w_sel       = r_grant[1];
   assign w_req       = w_sel ? bus.req1_request : bus.req0_request;
   assign w_stb       = w_sel ? bus.req1_strobe  : bus.req0_strobe;
   assign w_din       = w_sel ? bus.req1_data    : bus.req0_data;
   assign w_has_space = (r_count < bus.ppfifo_write_fifo_size);
   assign w_accept    = (r_grant != 2'b00) && w_stb && w_has_space;
   assign w_count_inc = r_count + 24'(w_accept);
   assign w_full      = (w_count_inc >= bus.ppfifo_write_fifo_size);

   assign w_any_req  = bus.req0_request | bus.req1_request;
   assign w_both_req = bus.req0_request & bus.req1_request;
   // Contested: the requester that did not win last time; otherwise whoever asks.
   assign w_win      = w_both_req ? ~r_last_grant : bus.req1_request;

`ifdef PPFIFO_WRITE_ARB_TIMEOUT_EN
   localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

   logic [IDLE_W-1:0] r_idle;

   always_ff @(posedge write_clock or posedge reset) begin
      if (reset) begin
         r_idle <= '0;
      end else if ((r_state != S_ACTIVE) || w_accept) begin
         r_idle <= '0;
      end else if (r_idle != IDLE_LAST) begin
         r_idle <= r_idle + 1'b1;
      end
   end

   // Fires on the idle cycle that brings the count to TIMEOUT_CYCLES.
   assign w_timeout = (r_state == S_ACTIVE) && !w_accept && (r_count != 24'd0) &&
                      (r_idle == IDLE_LAST);
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge write_clock or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_activate   <= 2'b00;
         r_grant      <= 2'b00;
         r_last_grant <= 1'b1;
         r_count      <= 24'd0;
         r_strobe     <= 1'b0;
         r_data       <= '0;
      end else begin
         r_state      <= w_state_next;
         r_activate   <= w_activate_next;
         r_grant      <= w_grant_next;
         r_last_grant <= w_last_grant_next;
         r_count      <= w_count_next;
         r_strobe     <= w_strobe_next;
         r_data       <= w_data_next;
      end
   end

   always_comb begin
      w_state_next      = r_state;
      w_activate_next   = r_activate;
      w_grant_next      = r_grant;
      w_last_grant_next = r_last_grant;
      w_count_next      = r_count;
      w_strobe_next     = 1'b0;
      w_data_next       = r_data;

      unique case (r_state)
         S_IDLE: begin
            if (w_any_req && (bus.ppfifo_write_ready != 2'b00)) begin
               w_activate_next = bus.ppfifo_write_ready[0] ? 2'b01 : 2'b10;
               w_grant_next    = w_win ? 2'b10 : 2'b01;
               if (w_both_req) begin
                  w_last_grant_next = w_win;
               end
               w_count_next = 24'd0;
               w_state_next = S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            if (w_accept) begin
               w_strobe_next = 1'b1;
               w_data_next   = w_din;
               w_count_next  = w_count_inc;
            end
            if (w_full || !w_req || w_timeout) begin
               w_grant_next = 2'b00;
               w_state_next = S_FLUSH;
            end
         end
         S_FLUSH: begin
            w_activate_next = 2'b00;
            w_state_next    = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   assign bus.req0_grant            = r_grant[0];
   assign bus.req1_grant            = r_grant[1];
   assign bus.req0_space            = r_grant[0] && w_has_space;
   assign bus.req1_space            = r_grant[1] && w_has_space;
   assign bus.ppfifo_write_activate = r_activate;
   assign bus.ppfifo_write_strobe   = r_strobe;
   assign bus.ppfifo_write_data     = r_data;
   assign bus.busy                  = (r_state != S_IDLE);

endmodule
